// File: rtl/n_bit_restoring_divider.sv
// Iterative unsigned N-bit restoring divider: one trial subtraction per clock behind a
// start/done handshake. The quotient and remainder hold until the next accepted start.
module n_bit_restoring_divider #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_quotient,
   output logic [N-1:0] o_remainder,
   output logic         o_div_by_zero
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [N-1:0]  r_q, w_q_nxt;
   logic [N-1:0]  r_d, w_d_nxt;
   logic [N:0]    r_r, w_r_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [N-1:0]  r_quot, w_quot_nxt;
   logic [N-1:0]  r_rem, w_rem_nxt;
   logic          r_dbz, w_dbz_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;

   logic [N:0]    w_rs, w_sub, w_t;
   logic          w_ge;
   logic [N-1:0]  w_q_shift;
   logic [N:0]    w_r_iter;

   assign w_rs  = {r_r[N-1:0], r_q[N-1]};
   assign w_sub = ~{1'b0, r_d};

   // Trial subtraction Rs - D as a ripple of full-adder cells with carry-in 1.
   // A carry out of the top cell means Rs >= D.
   always_comb begin
      logic c;
      // NOTE: the carry is a blocking-assigned local so each cell sees the previous cell's carry in the same pass.
      c   = 1'b1;
      w_t = '0;
      for (int b = 0; b <= N; b++) begin
         w_t[b] = w_rs[b] ^ w_sub[b] ^ c;
         c      = (w_rs[b] & w_sub[b]) | (c & (w_rs[b] ^ w_sub[b]));
      end
      w_ge = c;
   end

   assign w_q_shift = {r_q[N-2:0], w_ge};
   assign w_r_iter  = w_ge ? w_t : w_rs;

   // NOTE: every next-state value gets a hold default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_d_nxt     = r_d;
      w_r_nxt     = r_r;
      w_cnt_nxt   = r_cnt;
      w_quot_nxt  = r_quot;
      w_rem_nxt   = r_rem;
      w_dbz_nxt   = r_dbz;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (r_state == S_DONE && r_busy) begin
               // Divide-by-zero completion: the captured dividend is the remainder.
               w_quot_nxt = '1;
               w_rem_nxt  = r_q;
               w_dbz_nxt  = 1'b1;
               w_done_nxt = 1'b1;
               w_busy_nxt = 1'b0;
            end else if (i_start) begin
               w_q_nxt     = i_dividend;
               w_d_nxt     = i_divisor;
               w_r_nxt     = '0;
               w_quot_nxt  = '0;
               w_rem_nxt   = '0;
               w_dbz_nxt   = 1'b0;
               w_busy_nxt  = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = (i_divisor == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            w_q_nxt   = w_q_shift;
            w_r_nxt   = w_r_iter;
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) begin
               w_quot_nxt  = w_q_shift;
               w_rem_nxt   = w_r_iter[N-1:0];
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_d     <= '0;
         r_r     <= '0;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_d     <= w_d_nxt;
         r_r     <= w_r_nxt;
         r_cnt   <= w_cnt_nxt;
         r_quot  <= w_quot_nxt;
         r_rem   <= w_rem_nxt;
         r_dbz   <= w_dbz_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_quotient    = r_quot;
   assign o_remainder   = r_rem;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_n_bit_restoring_divider.sv
// Self-checking bench for n_bit_restoring_divider at N=8 and N=5: directed cases plus a
// random sweep checked against plain / and % arithmetic.
module tb_n_bit_restoring_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0, start5 = 1'b0;
   logic [7:0] dvd8 = '0, dvs8 = '0;
   logic [4:0] dvd5 = '0, dvs5 = '0;
   logic       busy8, done8, dbz8, busy5, done5, dbz5;
   logic [7:0] q8, r8;
   logic [4:0] q5, r5;

   int checks = 0;
   int errors = 0;
   bit sel5   = 1'b0;

   logic       w_busy, w_done, w_dbz;
   logic [7:0] w_q, w_r;

   always #5 clk = ~clk;

   n_bit_restoring_divider #(.N(8)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_start(start8), .i_dividend(dvd8), .i_divisor(dvs8),
      .o_busy(busy8), .o_done(done8), .o_quotient(q8), .o_remainder(r8), .o_div_by_zero(dbz8)
   );

   n_bit_restoring_divider #(.N(5)) dut5 (
      .i_clk(clk), .i_rst(rst), .i_start(start5), .i_dividend(dvd5), .i_divisor(dvs5),
      .o_busy(busy5), .o_done(done5), .o_quotient(q5), .o_remainder(r5), .o_div_by_zero(dbz5)
   );

   always_comb begin
      w_busy = busy8;
      w_done = done8;
      w_dbz  = dbz8;
      w_q    = q8;
      w_r    = r8;
      if (sel5) begin
         w_busy = busy5;
         w_done = done5;
         w_dbz  = dbz5;
         w_q    = {3'b000, q5};
         w_r    = {3'b000, r5};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b);
      if (sel5) begin
         start5 = s;
         dvd5   = a[4:0];
         dvs5   = b[4:0];
      end else begin
         start8 = s;
         dvd8   = a;
         dvs8   = b;
      end
   endtask

   // Counts edges after the accepting edge until done, bounded by a cycle budget.
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!w_done && lat < 40);
   endtask

   task automatic check_result(input string tag, input int n, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] mask, eq, er;
      mask = 8'((1 << n) - 1);
      if (b == 0) begin
         eq = mask;
         er = a;
      end else begin
         eq = a / b;
         er = a % b;
      end
      check({tag, " quotient"}, 32'(w_q), 32'(eq));
      check({tag, " remainder"}, 32'(w_r), 32'(er));
      check({tag, " div_by_zero"}, 32'(w_dbz), 32'(b == 0));
      check({tag, " busy at done"}, 32'(w_busy), 32'd0);
   endtask

   task automatic run_div(input string tag, input bit use5, input logic [7:0] a, input logic [7:0] b);
      int n, lat;
      sel5 = use5;
      n    = use5 ? 5 : 8;
      @(negedge clk);
      drive(1'b1, a, b);
      @(posedge clk);
      #1;
      drive(1'b0, 8'hA5, 8'h5A);
      check({tag, " busy after accept"}, 32'(w_busy), 32'd1);
      wait_done(lat);
      check({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(n));
      check_result(tag, n, a, b);
      @(posedge clk);
      #1;
      check({tag, " done falls"}, 32'(w_done), 32'd0);
   endtask

   initial begin
      int lat;
      logic [7:0] a, b;

      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy8), 32'd0);
      check("reset done", 32'(done8), 32'd0);
      check("reset quotient", 32'(q8), 32'd0);
      check("reset remainder", 32'(r8), 32'd0);
      check("reset dbz", 32'(dbz8), 32'd0);
      check("reset n5 outputs", 32'({busy5, done5, q5, r5, dbz5}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_div("200/7", 1'b0, 8'd200, 8'd7);
      run_div("5/9", 1'b0, 8'd5, 8'd9);
      run_div("255/1", 1'b0, 8'd255, 8'd1);
      run_div("3C/0", 1'b0, 8'h3C, 8'd0);
      run_div("10/3 after dbz", 1'b0, 8'd10, 8'd3);

      // Start held high across a whole divide with operands changing mid-flight.
      sel5 = 1'b0;
      @(negedge clk);
      drive(1'b1, 8'd100, 8'd10);
      @(posedge clk);
      #1;
      drive(1'b1, 8'd9, 8'd3);
      wait_done(lat);
      check("held start latency", 32'(lat), 32'd8);
      check_result("100/10 held start", 8, 8'd100, 8'd10);
      wait_done(lat);
      check("back-to-back done spacing", 32'(lat), 32'd9);
      drive(1'b0, 8'd0, 8'd0);
      check_result("9/3 back-to-back", 8, 8'd9, 8'd3);

      // Reset in the middle of a divide.
      @(negedge clk);
      drive(1'b1, 8'd200, 8'd7);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid reset busy", 32'(busy8), 32'd0);
      check("mid reset outputs", 32'({done8, q8, r8, dbz8}), 32'd0);
      // Simultaneous rst and start: the start is dropped.
      @(negedge clk);
      drive(1'b1, 8'd50, 8'd5);
      @(posedge clk);
      #1;
      check("rst beats start", 32'(busy8), 32'd0);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0);
      rst = 1'b0;
      run_div("17/4 after reset", 1'b0, 8'd17, 8'd4);

      // Random sweep with the interesting corner operands mixed in.
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (w == 1) begin
               a = a & 8'h1F;
               b = b & 8'h1F;
            end
            case (i % 6)
               0: b = 8'd1;
               1: b = a;
               2: b = 8'd0;
               default: ;
            endcase
            run_div((w == 1) ? "rand n5" : "rand n8", w == 1, a, b);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/n_bit_restoring_divider.md
# n_bit_restoring_divider

Iterative unsigned N-bit divider that computes quotient and remainder by restoring division, one trial subtraction per clock. It is the inverse-direction companion to the team's N-bit adder/subtractor: each iteration's trial subtraction is a ripple of full-adder cells with the subtrahend inverted and carry-in forced to 1. The block sits behind a simple start/done handshake, so control logic can issue divides without knowing the iteration count.

## Interface

- N, default 8: operand, quotient and remainder width; legal range 2..32.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is idle (state IDLE or DONE).
- dividend  in  N  unsigned dividend; captured on the accepting edge.
- divisor  in  N  unsigned divisor; captured on the accepting edge.
- busy  out  1  high while a divide is in progress; start is ignored.
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  N  result; holds until the next accepted start.
- remainder  out  N  result; holds until the next accepted start.
- div_by_zero  out  1  set with done when the captured divisor was 0; holds with the results.

## Operation

- States: IDLE, RUN, DONE.
- Reset (rst=1 at an edge, from any state, including mid-divide): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter=0.
- Accept: when state is IDLE or DONE and start=1:
  - capture dividend into Q and divisor into D;
  - clear the partial remainder R (N+1 bits);
  - clear the outputs quotient, remainder and div_by_zero;
  - busy=1, counter=0;
  - next state is RUN, or DONE directly if divisor==0.
- RUN iteration (one per edge, N total):
  - shift: Rs = {R[N-1:0], Q[N-1]}; Q <<= 1.
  - trial: T = Rs + ~{1'b0,D} + 1, computed at N+1 bits with carry-out c.
  - c=1 (Rs >= D): R=T[N:0], Q[0]=1. c=0: R=Rs (restore), Q[0]=0.
  - counter increments; the edge performing iteration N-1 also loads quotient=final Q and remainder=final R[N-1:0], clears busy, pulses done, and enters DONE.
- Divide by zero (divisor==0 at accept):
  - no iterations;
  - on the next edge: quotient = all ones, remainder = captured dividend, div_by_zero=1, done=1, busy=0, state DONE.
- DONE: done falls on the following edge. Outputs hold. State remains DONE (equivalent to IDLE) until the next start.
- start while busy=1: ignored. No queuing and no effect on the operation in flight.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic is unsigned only. R never exceeds D-1 after an iteration. No overflow is possible except the divide-by-zero case.

## Timing

- Accepting edge k: busy=1 visible after edge k.
- Normal divide: iterations occur on edges k+1..k+N. Edge k+N drives busy=0, done=1, and valid results. Latency is N cycles from accept to done.
- Divide by zero: edge k+1 drives done=1, busy=0, results. Latency is 1 cycle.
- done is high for exactly one cycle (edge k+N to edge k+N+1).
- Back-to-back operation: start=1 in the done cycle is accepted at edge k+N+1. Throughput is one divide per N+1 cycles.
- Simultaneous rst and start: rst wins; the start is dropped.
- Trial subtraction is a single-cycle combinational ripple of N+1 cells. The clock period must cover it.

## Test plan

- N=8, start with dividend=200, divisor=7 -> busy for 8 cycles, done pulse at edge k+8, quotient=28, remainder=4, div_by_zero=0.
- dividend=5, divisor=9 -> quotient=0, remainder=5 after 8 cycles; dividend=255, divisor=1 -> quotient=255, remainder=0.
- divisor=0, dividend=0x3C -> done at edge k+1, quotient=0xFF, remainder=0x3C, div_by_zero=1; the next divide of 10/3 clears div_by_zero and yields 3 r 1.
- Start 100/10 with start held high and operands changed to 9/3 while busy -> result 10 r 0. Start re-asserted in the done cycle with 9/3 -> second result 3 r 0, done exactly 9 edges after the first done.
- Assert rst at iteration 4 of 200/7 -> after that edge all outputs are 0 and busy=0. A fresh 17/4 then yields 4 r 1 with normal 8-cycle latency.
- Random sweep, N=8 and N=5, including divisor=1 and dividend=divisor -> quotient and remainder match dividend/divisor and dividend%divisor, done exactly once per accept.
